// File: rtl/onehot_pkg.sv
// Shared definitions for the one-hot decoder pipeline.
//   state_e     : top-level mode (pass-through decode or self-test sweep)
//   DefaultInW  : default binary code width
//   onehot_of() : reference decode, sized for the widest supported code.
//                 The encoder bench reuses it for round-trip checks.
package onehot_pkg;

  typedef enum logic {
    StPass,
    StSweep
  } state_e;

  localparam int unsigned DefaultInW = 3;

  // Widest code the shared decode function covers. Callers cast the result down to their width.
  localparam int unsigned MaxInW  = 5;
  localparam int unsigned MaxOutW = 2 ** MaxInW;

  function automatic logic [MaxOutW-1:0] onehot_of(input logic [MaxInW-1:0] code,
                                                  input logic              en);
    logic [MaxOutW-1:0] word;
    word = '0;
    if (en) begin
      word[code] = 1'b1;
    end
    return word;
  endfunction

endpackage

// File: rtl/onehot_skid_buf.sv
// Two-entry valid/ready buffer: an output register backed by one skid register.
// Gives full throughput under backpressure while in_ready depends only on
// registered state.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   hold                : forces in_ready low (owner is using the output itself)
//   in_valid / in_ready : upstream handshake, in_data is the word
//   out_valid/out_ready : downstream handshake, out_data is the word
module onehot_skid_buf #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         hold,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         in_xfer;
  logic         out_free;

  // No path from out_ready: a stalled consumer is absorbed by the skid entry.
  assign in_ready  = !hold && !skid_valid_q;
  assign in_xfer   = in_valid && in_ready;
  assign out_free  = !out_valid_q || out_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (out_free) begin
      if (skid_valid_q) begin
        // Skid holds the older word; in_ready is low so no input can race it.
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (in_xfer) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_xfer) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: rtl/onehot_decoder_pipe.sv
// Registered binary-to-one-hot decoder with valid/ready on both sides and a
// built-in sweep mode that emits every one-hot word in ascending order.
// Ports:
//   clk, rst_n                  : clock, synchronous active-low reset
//   in_valid / in_ready         : input handshake for code and en
//   code, en                    : binary index and decode enable (en=0 -> all-zero word)
//   sweep_start                 : single-cycle request to start a sweep (ignored unless idle)
//   sweep_busy                  : high while sweeping
//   out_valid / out_ready, y    : output handshake and decoded word
module onehot_decoder_pipe
  import onehot_pkg::*;
#(
  parameter int unsigned IN_W = DefaultInW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       code,
  input  logic                  en,
  input  logic                  sweep_start,
  output logic                  sweep_busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [(2**IN_W)-1:0]  y
);

  localparam int unsigned OUT_W = 2 ** IN_W;

  state_e            state_q, state_d;
  logic [IN_W-1:0]   k_q, k_d;
  logic [OUT_W-1:0]  dec_word;
  logic [OUT_W-1:0]  sweep_word;
  logic              buf_out_valid;
  logic [OUT_W-1:0]  buf_out_data;
  logic              sweeping;
  logic              in_xfer;

  assign sweeping   = (state_q == StSweep);
  assign sweep_busy = sweeping;
  assign in_xfer    = in_valid && in_ready;

  // Decode happens at acceptance; the buffer only captures it on an input transfer,
  // so don't-care code/en with in_valid=0 never reach state.
  assign dec_word   = OUT_W'(onehot_of(MaxInW'(code), en));
  assign sweep_word = OUT_W'(onehot_of(MaxInW'(k_q), 1'b1));

  onehot_skid_buf #(
    .W (OUT_W)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .hold      (sweeping),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (dec_word),
    .out_valid (buf_out_valid),
    .out_ready (out_ready),
    .out_data  (buf_out_data)
  );

  // The buffer is empty for the whole sweep, so the sweep word can own the output.
  always_comb begin
    out_valid = buf_out_valid;
    y         = buf_out_data;
    if (sweeping) begin
      out_valid = 1'b1;
      y         = sweep_word;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    unique case (state_q)
      StPass: begin
        // in_ready high in PASS means the skid is empty; an input transfer wins over sweep.
        if (sweep_start && !buf_out_valid && in_ready && !in_xfer) begin
          state_d = StSweep;
          k_d     = '0;
        end
      end
      StSweep: begin
        if (out_ready) begin
          if (&k_q) begin
            state_d = StPass;
            k_d     = '0;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StPass;
        k_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StPass;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

endmodule
